// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RV64 pipeline.
//
// Takes the execute result either as a pass-through writeback value or as a
// load/store byte address. Aligned loads/stores run a valid/ready request on
// the data-memory port (loads then wait for a response). Store data is shifted
// into its byte lanes, and load data is extracted and sign- or zero-extended.
// One registered writeback record is produced per instruction, and ex_ready
// stalls the execute stage while a memory transaction is outstanding.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid / ex_ready       instruction handshake from execute
//   ex_res                    ALU result / load-store address
//   ex_store_data             rs2 value for stores
//   ex_rd, ex_wen             destination register and its write enable
//   ex_load, ex_store         memory-op kind (both set -> load)
//   ex_funct3                 access size/signedness (B,H,W,D,BU,HU,WU; 111 = D)
//   mem_req_valid/ready       memory request handshake
//   mem_addr, mem_we          request address and write flag
//   mem_wdata, mem_wmask      lane-aligned store data and byte enables
//   mem_rsp_valid, mem_rdata  load response (aligned doubleword)
//   wb_valid, wb_rd, wb_wen,
//   wb_data, misalign         registered writeback record (one-cycle pulse)
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_res,
    input  logic [63:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_wen,
    output logic [63:0] wb_data,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Captured instruction
    logic [63:0] r_addr;
    logic [63:0] r_sdata;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic        r_load;
    logic [2:0]  r_funct3;

    // Registered writeback record
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic        r_wb_wen;
    logic [63:0] r_wb_data;
    logic        r_misalign;

    logic        w_xfer;
    logic        w_ex_mem;
    logic        w_ex_mis;
    logic        w_in_req;
    logic [2:0]  w_off;
    logic [7:0]  w_size_mask;
    logic [63:0] w_rshift;
    logic [63:0] w_ld_data;

    assign w_xfer   = ex_valid && (r_state == IDLE);
    assign w_ex_mem = ex_load || ex_store;
    assign w_in_req = (r_state == REQ);
    assign w_off    = r_addr[2:0];

    // funct3[1:0] encodes the size (B,H,W,D); 111 therefore falls out as D.
    always_comb begin
        w_ex_mis = 1'b0;
        case (ex_funct3[1:0])
            2'b00:   w_ex_mis = 1'b0;
            2'b01:   w_ex_mis = ex_res[0];
            2'b10:   w_ex_mis = |ex_res[1:0];
            default: w_ex_mis = |ex_res[2:0];
        endcase
    end

    always_comb begin
        w_size_mask = 8'hFF;
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // Load extraction: funct3[2] selects zero extension (BU/HU/WU; 111 is a full D).
    assign w_rshift = mem_rdata >> {w_off, 3'b000};
    always_comb begin
        w_ld_data = w_rshift;
        case (r_funct3[1:0])
            2'b00:   w_ld_data = {{56{w_rshift[7]  & ~r_funct3[2]}}, w_rshift[7:0]};
            2'b01:   w_ld_data = {{48{w_rshift[15] & ~r_funct3[2]}}, w_rshift[15:0]};
            2'b10:   w_ld_data = {{32{w_rshift[31] & ~r_funct3[2]}}, w_rshift[31:0]};
            default: w_ld_data = w_rshift;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_xfer && w_ex_mem && !w_ex_mis) w_state_next = REQ;
            REQ:  if (mem_req_ready) w_state_next = r_load ? RESP : IDLE;
            RESP: if (mem_rsp_valid) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: outputs. Bus fields are forced to 0 outside REQ so the port is quiet.
    always_comb begin
        ex_ready      = (r_state == IDLE);
        mem_req_valid = w_in_req;
        mem_addr      = w_in_req ? r_addr : 64'd0;
        mem_we        = w_in_req && !r_load;
        mem_wmask     = w_in_req ? (w_size_mask << w_off) : 8'd0;
        mem_wdata     = (w_in_req && !r_load) ? (r_sdata << {w_off, 3'b000}) : 64'd0;
    end

    // Instruction capture on every transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= 64'd0;
            r_sdata  <= 64'd0;
            r_rd     <= 5'd0;
            r_wen    <= 1'b0;
            r_load   <= 1'b0;
            r_funct3 <= 3'd0;
        end else if (w_xfer) begin
            r_addr   <= ex_res;
            r_sdata  <= ex_store_data;
            r_rd     <= ex_rd;
            r_wen    <= ex_wen;
            r_load   <= ex_load;
            r_funct3 <= ex_funct3;
        end
    end

    // Writeback record; valid/misalign are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_wen   <= 1'b0;
            r_wb_data  <= 64'd0;
            r_misalign <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer && !w_ex_mem) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= ex_rd;
                        r_wb_wen   <= ex_wen;
                        r_wb_data  <= ex_res;
                    end else if (w_xfer && w_ex_mis) begin
                        r_wb_valid <= 1'b1;
                        r_misalign <= 1'b1;
                        r_wb_rd    <= ex_rd;
                        r_wb_wen   <= 1'b0;
                        r_wb_data  <= 64'd0;
                    end
                end
                REQ: begin
                    if (mem_req_ready && !r_load) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_wen   <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_rsp_valid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_wen   <= r_wen;
                        r_wb_data  <= w_ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_wen   = r_wb_wen;
    assign wb_data  = r_wb_data;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_res;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] wb_data;
    logic        misalign;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_res(ex_res), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .wb_data(wb_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] res;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        wen;
        int          delay;
        logic [63:0] exp_data;
        logic        exp_wen;
        logic        exp_mis;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] res, input logic [63:0] sdata,
                                input logic [63:0] rdata, input logic [4:0] rd,
                                input logic wen, input int delay,
                                input logic [63:0] exp_data, input logic exp_wen,
                                input logic exp_mis, input logic [7:0] exp_mask,
                                input logic [63:0] exp_wdata);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.res = res; v.sdata = sdata;
        v.rdata = rdata; v.rd = rd; v.wen = wen; v.delay = delay;
        v.exp_data = exp_data; v.exp_wen = exp_wen; v.exp_mis = exp_mis;
        v.exp_mask = exp_mask; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Applies one vector starting in an IDLE cycle; ends in the cycle that
    // carries wb_valid so the next vector is issued back-to-back.
    task automatic run_vec(input vec_t v, input int idx);
        logic is_mem;
        is_mem = v.ld || v.st;
        chk("ex_ready_before", {63'd0, ex_ready}, 64'd1);
        ex_valid      = 1'b1;
        ex_res        = v.res;
        ex_store_data = v.sdata;
        ex_rd         = v.rd;
        ex_wen        = v.wen;
        ex_load       = v.ld;
        ex_store      = v.st;
        ex_funct3     = v.f3;
        tick();
        ex_valid = 1'b0;
        if (!is_mem || v.exp_mis) begin
            chk("wb_valid",  {63'd0, wb_valid}, 64'd1);
            chk("misalign",  {63'd0, misalign}, {63'd0, v.exp_mis});
            chk("wb_wen",    {63'd0, wb_wen},   {63'd0, v.exp_wen});
            chk("wb_data",   wb_data, v.exp_data);
            chk("no_req",    {63'd0, mem_req_valid}, 64'd0);
            if (!is_mem) chk("wb_rd", {59'd0, wb_rd}, {59'd0, v.rd});
        end else begin
            chk("wb_valid_early", {63'd0, wb_valid}, 64'd0);
            for (int i = 0; i <= v.delay; i++) begin
                chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
                chk("req_addr",  mem_addr, v.res);
                chk("req_we",    {63'd0, mem_we}, {63'd0, v.st && !v.ld});
                chk("req_wmask", {56'd0, mem_wmask}, {56'd0, v.exp_mask});
                chk("req_wdata", mem_wdata, v.exp_wdata);
                chk("ex_ready_stall", {63'd0, ex_ready}, 64'd0);
                if (i == v.delay) begin
                    mem_req_ready = 1'b1;
                    // Spurious response in the acceptance cycle must be ignored.
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                tick();
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
            end
            if (v.st && !v.ld) begin
                chk("st_wb_valid", {63'd0, wb_valid}, 64'd1);
                chk("st_wb_wen",   {63'd0, wb_wen}, 64'd0);
                chk("st_misalign", {63'd0, misalign}, 64'd0);
                chk("st_req_drop", {63'd0, mem_req_valid}, 64'd0);
            end else begin
                chk("resp_wait_wb", {63'd0, wb_valid}, 64'd0);
                chk("resp_no_req",  {63'd0, mem_req_valid}, 64'd0);
                mem_rsp_valid = 1'b1;
                mem_rdata     = v.rdata;
                tick();
                mem_rsp_valid = 1'b0;
                chk("ld_wb_valid", {63'd0, wb_valid}, 64'd1);
                chk("ld_wb_data",  wb_data, v.exp_data);
                chk("ld_wb_wen",   {63'd0, wb_wen}, {63'd0, v.exp_wen});
                chk("ld_wb_rd",    {59'd0, wb_rd}, {59'd0, v.rd});
                chk("ld_misalign", {63'd0, misalign}, 64'd0);
            end
        end
        $display("vec %0d: ld=%0b st=%0b f3=%0d addr=0x%h -> wb_data=0x%h wen=%0b mis=%0b",
                 idx, v.ld, v.st, v.f3, v.res, wb_data, wb_wen, misalign);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_res = '0; ex_store_data = '0; ex_rd = '0;
        ex_wen = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

        //        ld st f3      res            sdata                  rdata                  rd wen dly exp_data               ewen mis mask   wdata
        tbl.push_back(mk(0, 0, 3'b000, 64'h1234, 64'd0, 64'd0, 5'd3, 1, 0, 64'h1234, 1, 0, 8'h00, 64'd0));
        tbl.push_back(mk(0, 1, 3'b000, 64'h1005, 64'hAB, 64'd0, 5'd7, 0, 2, 64'd0, 0, 0, 8'h20, 64'h0000_AB00_0000_0000));
        tbl.push_back(mk(1, 0, 3'b000, 64'h2003, 64'd0, 64'h0000_0000_8000_0000, 5'd5, 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 8'h08, 64'd0));
        tbl.push_back(mk(1, 0, 3'b100, 64'h2003, 64'd0, 64'h0000_0000_8000_0000, 5'd6, 1, 0, 64'h80, 1, 0, 8'h08, 64'd0));
        tbl.push_back(mk(1, 0, 3'b010, 64'h2004, 64'd0, 64'h8000_0000_0000_0000, 5'd8, 1, 0, 64'hFFFF_FFFF_8000_0000, 1, 0, 8'hF0, 64'd0));
        tbl.push_back(mk(1, 0, 3'b110, 64'h2004, 64'd0, 64'h8000_0000_0000_0000, 5'd8, 1, 0, 64'h0000_0000_8000_0000, 1, 0, 8'hF0, 64'd0));
        tbl.push_back(mk(1, 0, 3'b010, 64'h3002, 64'd0, 64'd0, 5'd4, 1, 0, 64'd0, 0, 1, 8'h00, 64'd0));
        tbl.push_back(mk(1, 0, 3'b001, 64'h2006, 64'd0, 64'h1234_5678_9ABC_DEF0, 5'd10, 1, 0, 64'h1234, 1, 0, 8'hC0, 64'd0));
        tbl.push_back(mk(1, 0, 3'b001, 64'h2002, 64'd0, 64'h1234_5678_9ABC_DEF0, 5'd11, 1, 1, 64'hFFFF_FFFF_FFFF_9ABC, 1, 0, 8'h0C, 64'd0));
        tbl.push_back(mk(1, 0, 3'b101, 64'h2002, 64'd0, 64'h1234_5678_9ABC_DEF0, 5'd12, 1, 0, 64'h9ABC, 1, 0, 8'h0C, 64'd0));
        tbl.push_back(mk(1, 0, 3'b011, 64'h2008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd13, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 1, 0, 8'hFF, 64'd0));
        tbl.push_back(mk(0, 1, 3'b011, 64'h4000, 64'h1122_3344_5566_7788, 64'd0, 5'd0, 0, 0, 64'd0, 0, 0, 8'hFF, 64'h1122_3344_5566_7788));
        tbl.push_back(mk(0, 1, 3'b010, 64'h4004, 64'h1122_3344_AABB_CCDD, 64'd0, 5'd14, 1, 1, 64'd0, 0, 0, 8'hF0, 64'hAABB_CCDD_0000_0000));
        tbl.push_back(mk(0, 1, 3'b001, 64'h4006, 64'h0000_0000_0000_BEEF, 64'd0, 5'd0, 0, 3, 64'd0, 0, 0, 8'hC0, 64'hBEEF_0000_0000_0000));
        tbl.push_back(mk(0, 1, 3'b011, 64'h4001, 64'h55, 64'd0, 5'd2, 1, 0, 64'd0, 0, 1, 8'h00, 64'd0));
        tbl.push_back(mk(0, 1, 3'b001, 64'h4003, 64'h55, 64'd0, 5'd2, 1, 0, 64'd0, 0, 1, 8'h00, 64'd0));
        tbl.push_back(mk(1, 0, 3'b111, 64'h2010, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd15, 1, 0, 64'h0123_4567_89AB_CDEF, 1, 0, 8'hFF, 64'd0));
        tbl.push_back(mk(1, 1, 3'b000, 64'h2001, 64'hFF, 64'h0000_0000_0000_7F00, 5'd16, 1, 0, 64'h7F, 1, 0, 8'h02, 64'd0));
        tbl.push_back(mk(0, 0, 3'b000, 64'h55, 64'd0, 64'd0, 5'd9, 0, 0, 64'h55, 0, 0, 8'h00, 64'd0));
        tbl.push_back(mk(1, 0, 3'b101, 64'h2001, 64'd0, 64'd0, 5'd17, 1, 0, 64'd0, 0, 1, 8'h00, 64'd0));
        tbl.push_back(mk(1, 0, 3'b000, 64'h2000, 64'd0, 64'h0000_0000_0000_00FE, 5'd18, 1, 2, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 8'h01, 64'd0));

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ex_ready",  {63'd0, ex_ready}, 64'd1);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_wb_valid",  {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_data",   wb_data, 64'd0);
        chk("rst_misalign",  {63'd0, misalign}, 64'd0);
        chk("rst_wmask",     {56'd0, mem_wmask}, 64'd0);
        $display("reset: ex_ready=%0b wb_valid=%0b", ex_ready, wb_valid);

        // ALU stream, back to back, with spurious responses while IDLE
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int k = 1; k <= 3; k++) begin
            chk("stream_ex_ready", {63'd0, ex_ready}, 64'd1);
            ex_valid = 1'b1; ex_res = 64'(k); ex_rd = 5'(k); ex_wen = 1'b1;
            ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
            tick();
            chk("stream_wb_valid", {63'd0, wb_valid}, 64'd1);
            chk("stream_wb_data",  wb_data, 64'(k));
            chk("stream_no_req",   {63'd0, mem_req_valid}, 64'd0);
            $display("stream %0d: wb_valid=%0b wb_data=0x%h", k, wb_valid, wb_data);
        end
        ex_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b0;
        chk("stream_idle_wb", {63'd0, wb_valid}, 64'd0);

        foreach (tbl[i]) run_vec(tbl[i], i);
        tick();
        chk("post_table_wb", {63'd0, wb_valid}, 64'd0);

        // Reset while in RESP abandons the load
        ex_valid = 1'b1; ex_res = 64'h2008; ex_rd = 5'd20; ex_wen = 1'b1;
        ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b011;
        tick();
        ex_valid = 1'b0;
        chk("rr_req", {63'd0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rr_in_resp", {63'd0, ex_ready}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rr_wb_valid",  {63'd0, wb_valid}, 64'd0);
        chk("rr_wb_data",   wb_data, 64'd0);
        chk("rr_wb_rd",     {59'd0, wb_rd}, 64'd0);
        chk("rr_addr",      mem_addr, 64'd0);
        chk("rr_ex_ready",  {63'd0, ex_ready}, 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h1111_2222_3333_4444;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rr_late_rsp", {63'd0, wb_valid}, 64'd0);
        tick();
        chk("rr_late_rsp2", {63'd0, wb_valid}, 64'd0);
        $display("reset-in-resp: wb_valid=%0b ex_ready=%0b", wb_valid, ex_ready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
